// File: rtl/ucsbece154a_multicycle_controller.sv
// ucsbece154a_multicycle_controller
//   Moore-style sequencing FSM for a multicycle RV32I-subset core with a
//   shared instruction/data memory that can stall through mem_ready_i.
//   Supports lw, sw, R-type, I-type ALU, beq, jal and lui.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   op_i, funct3_i,
//   funct7b5_i        : instruction fields taken from IR
//   zero_i            : ALU zero flag (used for beq)
//   mem_ready_i       : memory access completes this cycle
//   PCWrite_o .. RegWrite_o : datapath enables and mux selects
//   state_o           : current FSM state (debug)
//   illegal_o         : sticky unsupported-instruction flag
module ucsbece154a_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ImmSrc_o,
  output logic [2:0] ALUControl_o,
  output logic       RegWrite_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_illegal_evt;
  logic       w_alu_ok;
  logic [2:0] w_alu_ctl;

  logic       w_pcw, w_adr, w_mw, w_irw, w_rw;
  logic [1:0] w_rs, w_sa, w_sb;
  logic [2:0] w_imm, w_alu;

  // ALU operation decode for the EXEC states; unknown funct3 flags illegal
  always_comb begin
    w_alu_ok  = 1'b1;
    w_alu_ctl = ALU_ADD;
    case (funct3_i)
      3'b000: begin
        // op_i[5] separates R-type (sub possible) from addi
        if (funct7b5_i & op_i[5]) begin
          w_alu_ctl = ALU_SUB;
        end else begin
          w_alu_ctl = ALU_ADD;
        end
      end
      3'b010: w_alu_ctl = ALU_SLT;
      3'b110: w_alu_ctl = ALU_OR;
      3'b111: w_alu_ctl = ALU_AND;
      default: begin
        w_alu_ok  = 1'b0;
        w_alu_ctl = ALU_ADD;
      end
    endcase
  end

  // Next-state logic and detection of unsupported instructions
  always_comb begin
    w_next        = S_FETCH;
    w_illegal_evt = 1'b0;
    case (r_state)
      S_FETCH:    w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          OP_LUI:       w_next = S_LUI;
          default: begin
            w_next        = S_FETCH;
            w_illegal_evt = 1'b1;
          end
        endcase
      end
      S_MEMADR:   w_next = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI: begin
        // a bad funct3 is flagged but the instruction still writes back
        w_next        = S_ALUWB;
        w_illegal_evt = ~w_alu_ok;
      end
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_LUI:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Moore output decode; only FETCH (mem_ready_i) and BEQ (zero_i) look at inputs
  always_comb begin
    w_pcw = 1'b0;   w_adr = 1'b0;   w_mw  = 1'b0;   w_irw = 1'b0;   w_rw = 1'b0;
    w_rs  = 2'b00;  w_sa  = 2'b00;  w_sb  = 2'b00;
    w_imm = 3'b000; w_alu = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_sb  = 2'b10;
        w_rs  = 2'b10;
        w_pcw = mem_ready_i;
        w_irw = mem_ready_i;
      end
      S_DECODE: begin
        w_sa  = 2'b01;
        w_sb  = 2'b01;
        w_imm = (op_i == OP_JAL) ? 3'b011 : 3'b010;
      end
      S_MEMADR: begin
        w_sa  = 2'b10;
        w_sb  = 2'b01;
        w_imm = (op_i == OP_SW) ? 3'b001 : 3'b000;
      end
      S_MEMREAD:  w_adr = 1'b1;
      S_MEMWB: begin
        w_rs = 2'b01;
        w_rw = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr = 1'b1;
        w_mw  = 1'b1;
      end
      S_EXECR: begin
        w_sa  = 2'b10;
        w_alu = w_alu_ctl;
      end
      S_EXECI: begin
        w_sa  = 2'b10;
        w_sb  = 2'b01;
        w_alu = w_alu_ctl;
      end
      S_ALUWB:    w_rw = 1'b1;
      S_BEQ: begin
        w_sa  = 2'b10;
        w_alu = ALU_SUB;
        w_pcw = zero_i;
      end
      S_JAL: begin
        w_sa  = 2'b01;
        w_sb  = 2'b10;
        w_pcw = 1'b1;
      end
      S_LUI: begin
        w_sa  = 2'b11;
        w_sb  = 2'b01;
        w_imm = 3'b100;
      end
      default: begin
        // unreachable encodings behave like FETCH
        w_sb  = 2'b10;
        w_rs  = 2'b10;
        w_pcw = mem_ready_i;
        w_irw = mem_ready_i;
      end
    endcase
  end

  // State register and sticky illegal flag; reset has priority over a fault
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_illegal_evt) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // enables are suppressed while reset is held so nothing architectural changes
  assign PCWrite_o    = w_pcw & ~reset;
  assign IRWrite_o    = w_irw & ~reset;
  assign MemWrite_o   = w_mw  & ~reset;
  assign RegWrite_o   = w_rw  & ~reset;
  assign AdrSrc_o     = w_adr;
  assign ResultSrc_o  = w_rs;
  assign ALUSrcA_o    = w_sa;
  assign ALUSrcB_o    = w_sb;
  assign ImmSrc_o     = w_imm;
  assign ALUControl_o = w_alu;
  assign state_o      = r_state;
  assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_ucsbece154a_multicycle_controller.sv
module tb_ucsbece154a_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] state;

  ucsbece154a_multicycle_controller dut (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .mem_ready_i(mem_ready),
    .PCWrite_o(PCWrite), .AdrSrc_o(AdrSrc), .MemWrite_o(MemWrite), .IRWrite_o(IRWrite),
    .ResultSrc_o(ResultSrc), .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .ImmSrc_o(ImmSrc),
    .ALUControl_o(ALUControl), .RegWrite_o(RegWrite), .state_o(state), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111;

  int checks = 0;
  int errors = 0;

  // expected outputs for the cycle about to be checked
  logic [3:0] e_st;
  logic       e_pcw, e_adr, e_mw, e_irw, e_rw, e_ill, pend_ill;
  logic [1:0] e_rs, e_sa, e_sb;
  logic [2:0] e_imm, e_alu;

  function automatic logic rb();
    return ($urandom_range(1, 0) == 1);
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL) || (o == LU);
  endfunction

  // {supported, ALU op} for an arithmetic instruction, straight from the ISA rules
  function automatic logic [3:0] alu_exp(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return {1'b1, (is_r && f7) ? 3'b001 : 3'b000};
      3'b010:  return {1'b1, 3'b101};
      3'b110:  return {1'b1, 3'b011};
      3'b111:  return {1'b1, 3'b010};
      default: return {1'b0, 3'b000};
    endcase
  endfunction

  task automatic dflt(input logic [3:0] st);
    e_st = st; e_pcw = 1'b0; e_adr = 1'b0; e_mw = 1'b0; e_irw = 1'b0; e_rw = 1'b0;
    e_rs = 2'b00; e_sa = 2'b00; e_sb = 2'b00; e_imm = 3'b000; e_alu = 3'b000;
  endtask

  task automatic fetch_exp();
    dflt(4'd0); e_sb = 2'b10; e_rs = 2'b10;
  endtask

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // one clock cycle: drive inputs, check at the falling edge, advance past the rising edge
  task automatic tick(input logic rst, input logic rdy, input logic z);
    reset = rst; mem_ready = rdy; zero = z;
    if (rst) begin
      e_pcw = 1'b0; e_irw = 1'b0; e_mw = 1'b0; e_rw = 1'b0;
    end
    #4;
    chk("state", {13'd0, state}, {13'd0, e_st});
    chk("ctrl", {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite},
                {e_pcw, e_adr, e_mw, e_irw, e_rs, e_sa, e_sb, e_imm, e_alu, e_rw});
    chk("illegal", {16'd0, illegal}, {16'd0, e_ill});
    @(posedge clk); #1;
    if (rst) e_ill = 1'b0;
    else if (pend_ill) e_ill = 1'b1;
    pend_ill = 1'b0;
  endtask

  task automatic aluwb();
    dflt(4'd8); e_rw = 1'b1; tick(1'b0, rb(), rb());
  endtask

  // full instruction from FETCH; wf/wm are memory wait cycles; rst_mem resets inside the memory access
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                           input int wf, input int wm, input logic rst_mem);
    logic [3:0] a;
    op = o; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < wf; i++) begin
      fetch_exp(); tick(1'b0, 1'b0, rb());
    end
    fetch_exp(); e_pcw = 1'b1; e_irw = 1'b1; tick(1'b0, 1'b1, rb());
    dflt(4'd1); e_sa = 2'b01; e_sb = 2'b01; e_imm = (o == JL) ? 3'b011 : 3'b010;
    pend_ill = !is_legal(o);
    tick(1'b0, rb(), rb());
    if (o == LW || o == SW) begin
      dflt(4'd2); e_sa = 2'b10; e_sb = 2'b01; e_imm = (o == SW) ? 3'b001 : 3'b000;
      tick(1'b0, rb(), rb());
      for (int i = 0; i < wm; i++) begin
        dflt((o == SW) ? 4'd5 : 4'd3); e_adr = 1'b1; e_mw = (o == SW); tick(1'b0, 1'b0, rb());
      end
      dflt((o == SW) ? 4'd5 : 4'd3); e_adr = 1'b1; e_mw = (o == SW);
      if (rst_mem) begin
        tick(1'b1, 1'b1, rb());
      end else begin
        tick(1'b0, 1'b1, rb());
        if (o == LW) begin
          dflt(4'd4); e_rs = 2'b01; e_rw = 1'b1; tick(1'b0, rb(), rb());
        end
      end
    end else if (o == RT || o == IT) begin
      a = alu_exp(o == RT, f3, f7);
      dflt((o == RT) ? 4'd6 : 4'd7); e_sa = 2'b10; e_sb = (o == RT) ? 2'b00 : 2'b01; e_alu = a[2:0];
      pend_ill = !a[3];
      tick(1'b0, rb(), rb());
      aluwb();
    end else if (o == BQ) begin
      dflt(4'd9); e_sa = 2'b10; e_alu = 3'b001; e_pcw = z; tick(1'b0, rb(), z);
    end else if (o == JL) begin
      dflt(4'd10); e_sa = 2'b01; e_sb = 2'b10; e_pcw = 1'b1; tick(1'b0, rb(), rb());
      aluwb();
    end else if (o == LU) begin
      dflt(4'd11); e_sa = 2'b11; e_sb = 2'b01; e_imm = 3'b100; tick(1'b0, rb(), rb());
      aluwb();
    end
  endtask

  initial begin
    logic [6:0] o;
    logic [6:0] ops [7];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BQ; ops[5] = JL; ops[6] = LU;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
    e_ill = 1'b0; pend_ill = 1'b0;
    @(posedge clk); #1;
    // reset values, enables suppressed even with memory ready
    fetch_exp(); tick(1'b1, 1'b1, 1'b0);

    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0);
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(RT, 3'b110, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(BQ, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(BQ, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(JL, 3'b000, 1'b0, 1'b0, 2, 0, 1'b0);
    run_instr(LU, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    // reset while lw waits in MEMREAD, then a clean fetch
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 2, 1'b1);
    run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);
    // reset while sw holds MemWrite
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 1, 1'b1);
    // unsupported opcode, then the flag persists until reset
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(IT, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0);
    fetch_exp(); tick(1'b1, 1'b1, 1'b0);
    run_instr(RT, 3'b100, 1'b0, 1'b0, 0, 0, 1'b0);
    fetch_exp(); tick(1'b1, 1'b0, 1'b0);

    // randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(9, 0) == 0) begin
        do o = 7'($urandom_range(127, 0)); while (is_legal(o));
      end else begin
        o = ops[$urandom_range(6, 0)];
      end
      run_instr(o, 3'($urandom_range(7, 0)), rb(), rb(), $urandom_range(3, 0), $urandom_range(3, 0),
                ($urandom_range(7, 0) == 0));
      if (n % 16 == 15) begin
        fetch_exp(); tick(1'b1, rb(), rb());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
